prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port en, input, 1 bit: start request, sampled only while rdy=1.
REQ-004 SHALL have port rdy, output, 1 bit: high = idle and able to accept en.
REQ-005 SHALL have port key, input, 24 bits: cipher key; unused by PRGA arithmetic, present for port compatibility.
REQ-006 SHALL have ports s_addr, output, 8 bits; s_rddata, input, 8 bits; s_wrdata, output, 8 bits; s_wren, output, 1 bit: port to the S memory (s_mem).
REQ-007 SHALL have ports ct_addr, output, 8 bits; ct_rddata, input, 8 bits: ciphertext read port.
REQ-008 SHALL have ports pt_addr, output, 8 bits; pt_rddata, input, 8 bits (ignored); pt_wrdata, output, 8 bits; pt_wren, output, 1 bit: plaintext write port.
REQ-009 s_mem SHALL be a 256x8 single-port synchronous RAM (address, clock, data, wren, q): write on the rising edge when wren=1; q valid one cycle after address is presented.

Function
REQ-010 SHALL assume 1-cycle read latency on both s_rddata and ct_rddata, and SHALL also work when ct_rddata is combinational.
REQ-011 SHALL drop rdy on the first clock edge at which en=1 and rdy=1, then run one message; en while rdy=0 SHALL be ignored.
REQ-012 SHALL read len=ct[0] and write pt[0]=len.
REQ-013 For k=1..len, with i,j 8-bit and initially 0, SHALL compute: i=i+1; j=j+S[i]; swap S[i] and S[j] in S memory; pad=S[(S[i]+S[j]) mod 256]; write pt[k]=ct[k] XOR pad.
REQ-014 All index arithmetic SHALL be modulo 256; i=j aliasing SHALL produce the correct swap, with the last write winning and both writes carrying the same value.
REQ-015 len=0 SHALL write only pt[0], then return to rdy=1.
REQ-016 State machine SHALL have states IDLE, RD_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, RD_CT, WR_PT, DONE; each RD_* SHALL include its wait cycle; WR_PT SHALL loop to RD_SI while k<len, else go to DONE; DONE SHALL go to IDLE with rdy=1.
REQ-017 Each message byte SHALL take at most 12 cycles; a 255-byte message SHALL complete within 3100 cycles of the en pulse.
REQ-018 s_wren and pt_wren SHALL each be single-cycle pulses, and only one memory write per port SHALL occur per cycle.
REQ-019 After completion, S memory SHALL hold the post-PRGA permuted state.

Reset
REQ-020 Asserting rst_n=0 SHALL immediately force: state IDLE, rdy=1, s_wren=0, pt_wren=0, all address and data outputs 0, i=j=k=0.
REQ-021 Reset during an operation SHALL abort it with no further writes; S and pt contents already written SHALL be left as they are.

Configuration
REQ-022 Macro PRGA_CT_PREFETCH_EN: when defined, the ct[k] read SHALL be issued in the same cycle as the S[i] read and the RD_CT state SHALL be skipped, giving at most 10 cycles per byte; when undefined, reads SHALL be sequential per REQ-016. Outputs SHALL be identical in both cases.

Verification
REQ-023 S preloaded with the KSA of key 00 01 55, ct = test1.memh, one-cycle en pulse -> rdy returns within 4000 cycles and pt[0..len] equals a software ARC4 model.
REQ-024 S = identity (S[x]=x), ct = {1, 0x00} -> pt = {1, 0x02}; S[1]=1 and S[0]=0 remain.
REQ-025 ct[0]=0 -> exactly one pt write (pt[0]=0), no S writes, rdy=1 within 12 cycles.
REQ-026 en held high for 5 cycles while busy -> exactly one message is processed, with no second run.
REQ-027 rst_n pulsed low mid-message -> rdy=1 and s_wren=pt_wren=0 immediately; a following en pulse runs cleanly.
REQ-028 ct[0]=255 with PRGA_CT_PREFETCH_EN defined and undefined -> identical pt contents; latency at most 3100 cycles when undefined and at most 2600 when defined.

Source files
------------

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: decrypts one length-prefixed message using the S permutation held in s_mem.
// Optional build macro PRGA_CT_PREFETCH_EN overlaps the ciphertext read with the S[i] read.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  input  logic [23:0] key,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, RD_CT, WR_PT, DONE
  } state_t;

  state_t     state_reg, state_next;
  logic       wait_reg, wait_next;
  logic [7:0] i_reg, j_reg, k_reg, len_reg;
  logic [7:0] si_reg, sj_reg, pad_reg, ct_reg;
  logic [7:0] pad_addr;
  logic       more;

  // Key and the plaintext read data are carried for port compatibility only.
  logic unused_inputs;
  assign unused_inputs = ^{key, pt_rddata};

  // Swapped values sum identically before and after the swap.
  assign pad_addr = si_reg + sj_reg;
  assign more     = (k_reg < len_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wait_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Every RD_* state spends a first cycle presenting the address and a second capturing the data.
  always_comb begin
    state_next = state_reg;
    wait_next  = 1'b0;
    case (state_reg)
      IDLE:   if (en) state_next = RD_LEN;
      RD_LEN: begin
        if (!wait_reg) wait_next = 1'b1;
        else           state_next = (ct_rddata == 8'd0) ? DONE : RD_SI;
      end
      RD_SI: begin
        if (!wait_reg) wait_next = 1'b1;
        else           state_next = RD_SJ;
      end
      RD_SJ: begin
        if (!wait_reg) wait_next = 1'b1;
        else           state_next = WR_SI;
      end
      WR_SI:  state_next = WR_SJ;
      WR_SJ:  state_next = RD_PAD;
      RD_PAD: begin
        if (!wait_reg) wait_next = 1'b1;
`ifdef PRGA_CT_PREFETCH_EN
        else           state_next = WR_PT;
`else
        else           state_next = RD_CT;
`endif
      end
      RD_CT: begin
        if (!wait_reg) wait_next = 1'b1;
        else           state_next = WR_PT;
      end
      WR_PT:  state_next = more ? RD_SI : DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg   <= 8'd0;
      j_reg   <= 8'd0;
      k_reg   <= 8'd0;
      len_reg <= 8'd0;
      si_reg  <= 8'd0;
      sj_reg  <= 8'd0;
      pad_reg <= 8'd0;
      ct_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (en) begin
          i_reg <= 8'd0;
          j_reg <= 8'd0;
          k_reg <= 8'd0;
        end
        RD_LEN: if (wait_reg) begin
          len_reg <= ct_rddata;
          if (ct_rddata != 8'd0) begin
            i_reg <= i_reg + 8'd1;
            k_reg <= k_reg + 8'd1;
          end
        end
        RD_SI: if (wait_reg) begin
          si_reg <= s_rddata;
          j_reg  <= j_reg + s_rddata;
`ifdef PRGA_CT_PREFETCH_EN
          ct_reg <= ct_rddata;
`endif
        end
        RD_SJ:  if (wait_reg) sj_reg  <= s_rddata;
        RD_PAD: if (wait_reg) pad_reg <= s_rddata;
        RD_CT:  if (wait_reg) ct_reg  <= ct_rddata;
        WR_PT: if (more) begin
          i_reg <= i_reg + 8'd1;
          k_reg <= k_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy       = (state_reg == IDLE);
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state_reg)
      RD_LEN: begin
        if (wait_reg) begin
          pt_wren   = 1'b1;
          pt_wrdata = ct_rddata;
        end
      end
      RD_SI: begin
        s_addr = i_reg;
`ifdef PRGA_CT_PREFETCH_EN
        ct_addr = k_reg;
`endif
      end
      RD_SJ:  s_addr = j_reg;
      WR_SI: begin
        s_addr   = i_reg;
        s_wrdata = sj_reg;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j_reg;
        s_wrdata = si_reg;
        s_wren   = 1'b1;
      end
      RD_PAD: s_addr  = pad_addr;
      RD_CT:  ct_addr = k_reg;
      WR_PT: begin
        pt_addr   = k_reg;
        pt_wrdata = ct_reg ^ pad_reg;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: table of messages against a software ARC4 model, plus reset/en corner sequences.
module tb_prga;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [23:0] key = 24'h000155;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic [7:0] pt_rddata = 8'd0;
  logic       pt_wren;

  always #5 clk = ~clk;

  prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  // Bench-side memories; tb_we gives the bench a preload path.
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0, tb_s = 8'd0, tb_ct = 8'd0;

  always @(posedge clk) begin
    if (tb_we) begin
      s_mem[tb_addr]  <= tb_s;
      ct_mem[tb_addr] <= tb_ct;
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  typedef struct {
    int kind;     // 0 identity S, 1 KSA of key, 2 keep current S
    int len;
    int pat;      // 0 zeros, 1 random, 2 ramp
    int max_cyc;
  } vec_t;

  vec_t       vecs [6];
  int         checks = 0;
  int         failures = 0;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;
  logic [7:0] model_s [256];
  logic [7:0] ct_arr [256];
  logic [7:0] pt_seen [256];
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle; DUT outputs sampled on the falling edge, pt writes scored here.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (pt_wren === 1'b1) begin
      pt_wr_cnt++;
      pt_seen[pt_addr] = pt_wrdata;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pt_extra_write: got addr=%0d data=0x%02h expected no write", pt_addr, pt_wrdata);
      end else begin
        e = exp_q.pop_front();
        check("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, e});
      end
    end
    if (s_wren === 1'b1) s_wr_cnt++;
  endtask

  task automatic set_s(input int kind);
    logic [7:0] j, t, kb;
    if (kind == 2) return;
    for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    if (kind == 1) begin
      j = 8'd0;
      for (int a = 0; a < 256; a++) begin
        kb = (a % 3 == 0) ? key[23:16] : (a % 3 == 1) ? key[15:8] : key[7:0];
        j = j + model_s[a] + kb;
        t = model_s[a];
        model_s[a] = model_s[j];
        model_s[j] = t;
      end
    end
  endtask

  task automatic fill_ct(input int len, input int pat);
    ct_arr[0] = 8'(len);
    for (int a = 1; a < 256; a++)
      ct_arr[a] = (pat == 0) ? 8'd0 : (pat == 1) ? 8'($urandom_range(0, 255)) : 8'(a * 7);
  endtask

  task automatic load();
    for (int a = 0; a < 256; a++) begin
      tb_we = 1'b1;
      tb_addr = 8'(a);
      tb_s = model_s[a];
      tb_ct = ct_arr[a];
      tick();
    end
    tb_we = 1'b0;
  endtask

  // Software ARC4 PRGA; pushes the expected pt writes in order.
  task automatic model_run(input int len);
    logic [7:0] i, j, t, pad;
    exp_q.push_back({8'd0, 8'(len)});
    i = 8'd0;
    j = 8'd0;
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      j = j + model_s[i];
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
      pad = model_s[8'(model_s[i] + model_s[j])];
      exp_q.push_back({8'(k), ct_arr[k] ^ pad});
    end
  endtask

  task automatic wait_rdy(input string name, input int max_cyc, input int start_cyc);
    int cyc;
    cyc = start_cyc;
    while (rdy !== 1'b1 && cyc < 4000) begin
      tick();
      cyc++;
    end
    check({name, "_rdy_return"}, {31'd0, rdy}, 32'd1);
    checks++;
    if (cyc > max_cyc) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles expected at most %0d", name, cyc, max_cyc);
    end
  endtask

  task automatic run_msg(input string name, input int len, input int max_cyc);
    int s0, p0, mism;
    s0 = s_wr_cnt;
    p0 = pt_wr_cnt;
    model_run(len);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_rdy(name, max_cyc, 1);
    check({name, "_sb_drained"}, exp_q.size(), 0);
    check({name, "_pt_writes"}, pt_wr_cnt - p0, len + 1);
    check({name, "_s_writes"}, s_wr_cnt - s0, 2 * len);
    mism = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== model_s[a]) mism++;
    check({name, "_s_final_mismatches"}, mism, 0);
  endtask

  initial begin
    int p0, s0, n255;
`ifdef PRGA_CT_PREFETCH_EN
    n255 = 2600;
`else
    n255 = 3100;
`endif
    vecs[0] = '{kind: 1, len: 20,  pat: 1, max_cyc: 252};
    vecs[1] = '{kind: 0, len: 0,   pat: 0, max_cyc: 12};
    vecs[2] = '{kind: 2, len: 5,   pat: 2, max_cyc: 72};
    vecs[3] = '{kind: 1, len: 255, pat: 1, max_cyc: n255};
    vecs[4] = '{kind: 2, len: 1,   pat: 2, max_cyc: 24};
    vecs[5] = '{kind: 0, len: 40,  pat: 0, max_cyc: 492};

    #1;
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_outputs", {s_wren, pt_wren, s_addr, ct_addr, pt_addr},
          {2'b00, 24'd0});
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      set_s(vecs[v].kind);
      fill_ct(vecs[v].len, vecs[v].pat);
      load();
      run_msg($sformatf("vec%0d", v), vecs[v].len, vecs[v].max_cyc);
    end

    // Identity S with one zero byte: i=j=1, pad=S[2]=2.
    set_s(0);
    fill_ct(1, 0);
    load();
    run_msg("identity1", 1, 24);
    check("identity1_pt1", {24'd0, pt_seen[1]}, 32'h02);
    check("identity1_s1", {24'd0, s_mem[1]}, 32'h01);
    check("identity1_s0", {24'd0, s_mem[0]}, 32'h00);

    // en held for 5 cycles while busy must yield a single run.
    set_s(0);
    fill_ct(3, 1);
    load();
    p0 = pt_wr_cnt;
    model_run(3);
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    wait_rdy("hold_en", 48, 5);
    repeat (30) tick();
    check("hold_en_pt_writes", pt_wr_cnt - p0, 4);
    check("hold_en_idle", {31'd0, rdy}, 32'd1);
    check("hold_en_sb_drained", exp_q.size(), 0);

    // Asynchronous reset mid-message, then a clean run.
    set_s(0);
    fill_ct(50, 1);
    load();
    model_run(50);
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (100) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rdy", {31'd0, rdy}, 32'd1);
    check("midreset_wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("midreset_addr_data", {s_addr, ct_addr, pt_addr, s_wrdata | pt_wrdata}, 32'd0);
    exp_q.delete();
    p0 = pt_wr_cnt;
    s0 = s_wr_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midreset_no_writes", (pt_wr_cnt - p0) + (s_wr_cnt - s0), 0);
    set_s(0);
    fill_ct(10, 2);
    load();
    run_msg("after_reset", 10, 132);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
